// File: rtl/load_store_unit.sv
// Memory-access stage: aligns stores onto byte lanes, extracts/extends loads,
// and runs a valid/ready request + response handshake, stalling upstream until done.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            SizeCtrl,
  input  logic [ADDR_WIDTH-1:0] ALUResult,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Stall,
  output logic                  MisalignErr,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wstrb,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t          r_state;
  logic [1:0]      r_off;
  logic            r_byte, r_half, r_uns;
  logic            w_access, w_store, w_byte, w_half, w_misalign;
  logic [3:0]      w_wstrb;
  logic [DATA_WIDTH-1:0] w_wdata, w_shift, w_ext;

  assign w_access = MemRead | MemWrite;
  assign w_store  = MemWrite;
  // Undefined size codes fall through to word.
  assign w_byte   = (SizeCtrl == 3'b000) || (SizeCtrl == 3'b100);
  assign w_half   = (SizeCtrl == 3'b001) || (SizeCtrl == 3'b101);
  assign w_misalign = w_half ? ALUResult[0] :
                      w_byte ? 1'b0 : (ALUResult[1:0] != 2'b00);

  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = WriteData;
    if (w_byte) begin
      w_wstrb = 4'b0001 << ALUResult[1:0];
      w_wdata = DATA_WIDTH'({4{WriteData[7:0]}});
    end else if (w_half) begin
      w_wstrb = ALUResult[1] ? 4'b1100 : 4'b0011;
      w_wdata = DATA_WIDTH'({2{WriteData[15:0]}});
    end
  end

  assign w_shift = mem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ext = w_shift;
    if (r_byte)
      w_ext = {{(DATA_WIDTH-8){~r_uns & w_shift[7]}}, w_shift[7:0]};
    else if (r_half)
      w_ext = {{(DATA_WIDTH-16){~r_uns & w_shift[15]}}, w_shift[15:0]};
  end

  assign Stall = ((r_state == IDLE) && w_access && !w_misalign) ||
                 (r_state == REQ) || (r_state == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      ReadData      <= '0;
      MisalignErr   <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wstrb     <= 4'b0000;
      mem_wdata     <= '0;
      r_off         <= 2'b00;
      r_byte        <= 1'b0;
      r_half        <= 1'b0;
      r_uns         <= 1'b0;
    end else begin
      MisalignErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_access && w_misalign) begin
            MisalignErr <= 1'b1;
          end else if (w_access) begin
            r_state       <= REQ;
            mem_req_valid <= 1'b1;
            mem_we        <= w_store;
            mem_addr      <= {ALUResult[ADDR_WIDTH-1:2], 2'b00};
            mem_wstrb     <= w_store ? w_wstrb : 4'b0000;
            mem_wdata     <= w_store ? w_wdata : '0;
            r_off         <= ALUResult[1:0];
            r_byte        <= w_byte;
            r_half        <= w_half;
            r_uns         <= SizeCtrl[2];
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            r_state       <= mem_we ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            ReadData <= w_ext;
            r_state  <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a reactive memory, a byte-level reference
// model checked every cycle, and hand-computed literals per access.
module tb_load_store_unit;
  logic        clk = 0, rst_n = 0;
  logic        MemRead = 0, MemWrite = 0;
  logic [2:0]  SizeCtrl = 0;
  logic [31:0] ALUResult = 0, WriteData = 0, ReadData;
  logic        Stall, MisalignErr, mem_req_valid, mem_we;
  logic        mem_req_ready = 0, mem_rsp_valid = 0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0;
  logic [3:0]  mem_wstrb;

  int pass_cnt = 0, total_cnt = 0;
  bit chk_en = 0, exp_mis = 0, cur_mis = 0;
  logic [31:0] exp_rd = 0;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .SizeCtrl(SizeCtrl), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .Stall(Stall), .MisalignErr(MisalignErr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference model: access size in bytes, lane mapping and load value.
  function automatic int m_nbytes(input logic [2:0] sz);
    if (sz == 3'b000 || sz == 3'b100) return 1;
    if (sz == 3'b001 || sz == 3'b101) return 2;
    return 4;
  endfunction

  function automatic bit m_mis(input logic [2:0] sz, input logic [31:0] a);
    return (a % m_nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] sz, input logic [31:0] a);
    logic [3:0] s = 0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(a % 4) && i < int'(a % 4) + m_nbytes(sz)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] r = 0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % m_nbytes(sz)) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [1:0] off,
                                         input logic [31:0] w);
    logic [31:0] s;
    int n;
    n = m_nbytes(sz);
    s = w >> (8 * off);
    if (n == 4) return s;
    s = s & ((32'h1 << (8 * n)) - 1);
    if (!sz[2] && s[8*n-1]) s = s - (32'h1 << (8 * n));
    return s;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("misalign_err", {31'b0, MisalignErr}, {31'b0, exp_mis});
      chk("read_data", ReadData, exp_rd);
      if (cur_mis) chk("no_request", {31'b0, mem_req_valid}, 32'h0);
      if (mem_req_valid) begin
        chk("req_addr", mem_addr, ALUResult & ~32'h3);
        chk("req_we", {31'b0, mem_we}, {31'b0, MemWrite});
        chk("req_wstrb", {28'b0, mem_wstrb}, MemWrite ? {28'b0, m_strb(SizeCtrl, ALUResult)} : 32'h0);
        if (MemWrite) chk("req_wdata", mem_wdata, m_wdata(SizeCtrl, WriteData));
      end
    end
  end

  task automatic access(input bit rd, input bit wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                        input int rdy_dly, input int rsp_dly,
                        input logic [31:0] lit_rd, input int lit_stall,
                        input logic [3:0] lit_strb, input logic [31:0] lit_wdata);
    int stalls = 0, rc = 0, wc = 0, cyc = 0, mstall;
    bit hs = 0, sent = 0, fin = 0, mis;
    mis = m_mis(sz, a);
    mstall = mis ? 0 : (wr ? 2 + rdy_dly : 3 + rdy_dly + rsp_dly);
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; SizeCtrl = sz; ALUResult = a; WriteData = wd;
    cur_mis = mis;
    while (!fin && cyc < 60) begin
      if (mem_rsp_valid) begin
        mem_rsp_valid = 0;
        exp_rd = m_load(sz, a[1:0], rword);
      end
      mem_req_ready = mem_req_valid && (rc >= rdy_dly);
      if (hs && !wr && !sent) begin
        if (wc >= rsp_dly) begin mem_rsp_valid = 1; mem_rdata = rword; sent = 1; end
        wc++;
      end
      @(negedge clk);
      if (Stall) stalls++; else fin = 1;
      if (mem_req_valid) begin
        if (mem_req_ready) begin
          hs = 1;
          chk("lit_addr", mem_addr, {a[31:2], 2'b00});
          chk("lit_wstrb", {28'b0, mem_wstrb}, {28'b0, lit_strb});
          if (wr) chk("lit_wdata", mem_wdata, lit_wdata);
        end else rc++;
      end
      if (!fin) begin @(posedge clk); #1; cyc++; end
    end
    if (!fin) chk("timeout", 32'h1, 32'h0);
    chk("stall_cycles", stalls, lit_stall);
    chk("stall_model", stalls, mstall);
    chk("lit_read_data", ReadData, lit_rd);
    @(posedge clk); #1;
    MemRead = 0; MemWrite = 0; mem_req_ready = 0; cur_mis = 0;
    exp_mis = mis;
    @(posedge clk); #1;
    exp_mis = 0;
  endtask

  initial begin
    #12;
    chk("rst_read_data", ReadData, 32'h0);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("rst_misalign", {31'b0, MisalignErr}, 32'h0);
    chk("rst_wstrb", {28'b0, mem_wstrb}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    @(posedge clk); #1; rst_n = 1; chk_en = 1;

    access(1,0,3'b010,32'h100,0,32'hDEADBEEF,0,0,32'hDEADBEEF,3,4'b0000,0);
    access(1,0,3'b000,32'h103,0,32'h80112233,0,0,32'hFFFFFF80,3,4'b0000,0);
    access(1,0,3'b100,32'h103,0,32'h80112233,0,0,32'h00000080,3,4'b0000,0);
    access(1,0,3'b001,32'h102,0,32'h80112233,0,0,32'hFFFF8011,3,4'b0000,0);
    access(1,0,3'b101,32'h102,0,32'h80112233,0,0,32'h00008011,3,4'b0000,0);
    access(0,1,3'b000,32'h201,32'h000000AB,0,0,0,32'h00008011,2,4'b0010,32'hABABABAB);
    access(0,1,3'b001,32'h202,32'h00001234,0,0,0,32'h00008011,2,4'b1100,32'h12341234);
    access(1,0,3'b010,32'h102,0,32'h0,0,0,32'h00008011,0,4'b0000,0);
    access(1,0,3'b010,32'h104,0,32'hCAFEF00D,3,2,32'hCAFEF00D,8,4'b0000,0);
    access(0,1,3'b010,32'h108,32'h11223344,0,1,0,32'hCAFEF00D,3,4'b1111,32'h11223344);
    access(1,0,3'b000,32'h100,0,32'h0000007F,0,0,32'h0000007F,3,4'b0000,0);
    access(1,0,3'b011,32'h10C,0,32'h89ABCDEF,0,0,32'h89ABCDEF,3,4'b0000,0);
    access(1,1,3'b000,32'h10E,32'h0000005A,0,0,0,32'h89ABCDEF,2,4'b0100,32'h5A5A5A5A);
    access(1,0,3'b001,32'h101,0,32'h0,0,0,32'h89ABCDEF,0,4'b0000,0);
    access(0,1,3'b001,32'h203,32'h0000BEEF,0,0,0,32'h89ABCDEF,0,4'b0000,0);
    access(1,0,3'b101,32'h100,0,32'hFFFF1234,0,1,32'h00001234,4,4'b0000,0);

    // Reset while a load waits for its response; a late response must be ignored.
    @(posedge clk); #1;
    MemRead = 1; SizeCtrl = 3'b010; ALUResult = 32'h110; mem_req_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_req_ready = 0;
    chk_en = 0;
    #2 rst_n = 0; MemRead = 0;
    #1;
    chk("wait_rst_read_data", ReadData, 32'h0);
    chk("wait_rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
    chk("wait_rst_we", {31'b0, mem_we}, 32'h0);
    chk("wait_rst_addr", mem_addr, 32'h0);
    chk("wait_rst_wdata", mem_wdata, 32'h0);
    chk("wait_rst_stall", {31'b0, Stall}, 32'h0);
    @(posedge clk); #1; rst_n = 1;
    mem_rsp_valid = 1; mem_rdata = 32'h55555555;
    @(negedge clk);
    chk("late_rsp_stall", {31'b0, Stall}, 32'h0);
    @(posedge clk); #1; mem_rsp_valid = 0;
    @(negedge clk);
    chk("late_rsp_read_data", ReadData, 32'h0);
    chk("late_rsp_req_valid", {31'b0, mem_req_valid}, 32'h0);
    exp_rd = 0; chk_en = 1;

    access(1,0,3'b010,32'h110,0,32'h13579BDF,0,0,32'h13579BDF,3,4'b0000,0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
